// File: rtl/sh7034_extbus_responder.sv
// SH7034 external-bus target: decodes one CS area, stretches the CPU cycle with WAIT_N
// and bridges each access onto a req/ack memory port, optionally posting one write.
module sh7034_extbus_responder #(
  parameter int ADDR_W  = 21,
  parameter int BUS8    = 0,
  parameter int POST_WR = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic              CE_F,
  input  logic [23:0]       A,
  input  logic [15:0]       DI,
  output logic [15:0]       DO,
  output logic              DO_OE,
  input  logic              CS_N,
  input  logic              RD_N,
  input  logic              WRH_N,
  input  logic              WRL_N,
  output logic              WAIT_N,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [15:0]       MEM_DO,
  input  logic [15:0]       MEM_DI,
  output logic [1:0]        MEM_BE,
  output logic              MEM_WE,
  output logic              MEM_REQ,
  input  logic              MEM_ACK
);

  typedef enum logic [2:0] {IDLE, RD_MEM, WR_MEM, HOLD, DRAIN} state_t;

  state_t             state, state_nx;
  logic               wait_r, wait_nx;
  logic [15:0]        do_r, do_nx;
  logic               oe_r, oe_nx;
  logic               req_r, req_nx;
  logic               we_r, we_nx;
  logic [1:0]         be_r, be_nx;
  logic [ADDR_W-1:0]  a_r, a_nx;
  logic [15:0]        wd_r, wd_nx;
  logic               pend, pend_nx;
  logic               abort, abort_nx;

  logic               ack, det, strobe, launch;
  logic [ADDR_W-1:0]  acc_a;
  logic [1:0]         acc_be;
  logic [15:0]        acc_do, rd_data;
  logic               unused_bits;

  assign unused_bits = ^{CE_F, A};

  assign strobe = !RD_N || !WRH_N || !WRL_N;
  assign det    = CE_R && !CS_N && strobe;
  // ACK is only meaningful against an outstanding request; stray ACKs are dropped.
  assign ack    = MEM_ACK && req_r;

  assign acc_a  = (BUS8 != 0) ? A[ADDR_W-1:0] : A[ADDR_W:1];
  assign acc_be = (BUS8 != 0) ? (A[0] ? 2'b01 : 2'b10)
                : (!RD_N ? 2'b11 : {~WRH_N, ~WRL_N});
  assign acc_do = (BUS8 != 0) ? {DI[7:0], DI[7:0]} : DI;
  assign rd_data = (BUS8 != 0) ? {8'h00, (be_r[1] ? MEM_DI[15:8] : MEM_DI[7:0])} : MEM_DI;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wait_nx  = wait_r;
    do_nx    = do_r;
    oe_nx    = oe_r;
    req_nx   = req_r;
    we_nx    = we_r;
    be_nx    = be_r;
    a_nx     = a_r;
    wd_nx    = wd_r;
    pend_nx  = pend;
    abort_nx = abort;
    launch   = 1'b0;

    // Background completion: also drains a posted write from any state.
    if (ack) begin
      req_nx  = 1'b0;
      pend_nx = 1'b0;
    end

    case (state)
      IDLE: begin
        if (det) begin
          if (pend && !ack) begin
            wait_nx  = 1'b0;
            state_nx = DRAIN;
          end else begin
            launch = 1'b1;
          end
        end
      end
      RD_MEM: begin
        if (ack) begin
          wait_nx = 1'b1;
          if (abort || CS_N) begin
            state_nx = IDLE;
          end else begin
            do_nx    = rd_data;
            oe_nx    = 1'b1;
            state_nx = HOLD;
          end
        end else if (CS_N) begin
          abort_nx = 1'b1;
        end
      end
      WR_MEM: begin
        if (ack) begin
          wait_nx  = 1'b1;
          state_nx = (abort || CS_N) ? IDLE : HOLD;
        end else if (CS_N) begin
          abort_nx = 1'b1;
        end
      end
      DRAIN: begin
        // The CPU is still stalled on a qualified access; restart it directly.
        if (ack) begin
          if (abort || CS_N || !strobe) begin
            wait_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            launch = 1'b1;
          end
        end else if (CS_N) begin
          abort_nx = 1'b1;
        end
      end
      HOLD: begin
        if (CS_N || !strobe) begin
          oe_nx    = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (launch) begin
      abort_nx = 1'b0;
      a_nx     = acc_a;
      be_nx    = acc_be;
      req_nx   = 1'b1;
      if (!RD_N) begin
        we_nx    = 1'b0;
        wait_nx  = 1'b0;
        state_nx = RD_MEM;
      end else begin
        we_nx = 1'b1;
        wd_nx = acc_do;
        if (POST_WR != 0) begin
          pend_nx  = 1'b1;
          wait_nx  = 1'b1;
          state_nx = HOLD;
        end else begin
          wait_nx  = 1'b0;
          state_nx = WR_MEM;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wait_r <= 1'b1;
      do_r   <= '0;
      oe_r   <= 1'b0;
      req_r  <= 1'b0;
      we_r   <= 1'b0;
      be_r   <= '0;
      a_r    <= '0;
      wd_r   <= '0;
      pend   <= 1'b0;
      abort  <= 1'b0;
    end else begin
      wait_r <= wait_nx;
      do_r   <= do_nx;
      oe_r   <= oe_nx;
      req_r  <= req_nx;
      we_r   <= we_nx;
      be_r   <= be_nx;
      a_r    <= a_nx;
      wd_r   <= wd_nx;
      pend   <= pend_nx;
      abort  <= abort_nx;
    end
  end

  assign WAIT_N  = wait_r;
  assign DO      = do_r;
  assign DO_OE   = oe_r;
  assign MEM_REQ = req_r;
  assign MEM_WE  = we_r;
  assign MEM_BE  = be_r;
  assign MEM_A   = a_r;
  assign MEM_DO  = wd_r;

endmodule
